// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode/funct constants, request kinds and encoder state shared with the decoder
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_ADDI = 4'd7,
    K_ANDI = 4'd8,
    K_ORI  = 4'd9,
    K_SLTI = 4'd10,
    K_BEQ  = 4'd11,
    K_BNE  = 4'd12,
    K_J    = 4'd13
  } instr_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } enc_state_t;

  function automatic logic is_branch(input logic [3:0] kind);
    return (kind == K_BEQ) || (kind == K_BNE) || (kind == K_J);
  endfunction

endpackage

// File: rtl/instr_word_enc.sv
// rtl/instr_word_enc.sv - combinational request-to-MIPS-word encoder with legality flag
module instr_word_enc
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      K_OR:    word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      K_LW:    word = {OP_LW,   rs, rt, imm};
      K_SW:    word = {OP_SW,   rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_ANDI:  word = {OP_ANDI, rs, rt, imm};
      K_ORI:   word = {OP_ORI,  rs, rt, imm};
      K_SLTI:  word = {OP_SLTI, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      K_BNE:   word = {OP_BNE,  rs, rt, imm};
      K_J:     word = {OP_J, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// rtl/instr_stream_encoder.sv - streams encoded MIPS words into imem at auto-incrementing addresses
// Optional branch delay-slot NOP padding: INSTR_ENC_DELAY_SLOT_EN.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic          err_overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  enc_state_t    state;
  logic [AW-1:0] ptr;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic          slot_ok;

  instr_word_enc u_enc (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

`ifdef INSTR_ENC_DELAY_SLOT_EN
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
  logic nop_pend;
  logic fin_pend;
  // A branch needs two slots: itself plus its trailing NOP.
  assign slot_ok = !nop_pend && !(is_branch(in_kind) && (count >= DEPTH_M1));
`else
  assign slot_ok = 1'b1;
`endif

  assign in_ready = (state == ST_LOAD) && (count < DEPTH_C) && slot_ok;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      count        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wd      <= '0;
      done         <= 1'b0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
`ifdef INSTR_ENC_DELAY_SLOT_EN
      nop_pend     <= 1'b0;
      fin_pend     <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        // Restart discards any request accepted in this same cycle.
        state        <= ST_LOAD;
        ptr          <= base_addr;
        count        <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
`ifdef INSTR_ENC_DELAY_SLOT_EN
        nop_pend     <= 1'b0;
        fin_pend     <= 1'b0;
`endif
      end else if (state == ST_LOAD) begin
        if (in_valid && (count == DEPTH_C)) err_overflow <= 1'b1;
        if (accept && !enc_legal)           err_illegal  <= 1'b1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
        if (nop_pend) begin
          imem_we   <= 1'b1;
          imem_addr <= ptr;
          imem_wd   <= '0;
          ptr       <= ptr + 1'b1;
          count     <= count + 1'b1;
          nop_pend  <= 1'b0;
          if (finish || fin_pend) begin
            state    <= ST_IDLE;
            done     <= 1'b1;
            fin_pend <= 1'b0;
          end
        end else begin
          if (accept && enc_legal) begin
            imem_we   <= 1'b1;
            imem_addr <= ptr;
            imem_wd   <= enc_word;
            ptr       <= ptr + 1'b1;
            count     <= count + 1'b1;
            if (is_branch(in_kind)) nop_pend <= 1'b1;
          end
          if (finish) begin
            if (accept && enc_legal && is_branch(in_kind)) begin
              fin_pend <= 1'b1;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
`else
        if (accept && enc_legal) begin
          imem_we   <= 1'b1;
          imem_addr <= ptr;
          imem_wd   <= enc_word;
          ptr       <= ptr + 1'b1;
          count     <= count + 1'b1;
        end
        if (finish) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb/tb_instr_stream_encoder.sv - table-driven scoreboard bench for instr_stream_encoder (AW=6, DEPTH=4)
module tb_instr_stream_encoder;

  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, finish, in_valid;
  logic [AW-1:0] base_addr;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          busy, done, err_illegal, err_overflow;
  logic [AW:0]   count;

  instr_stream_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd), .busy(busy),
    .done(done), .count(count), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] wd;
    logic        legal;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wd;
  } wr_t;

  vec_t      tbl[17];
  wr_t       sb[$];
  int        n_total = 0;
  int        n_pass  = 0;
  logic          m_load = 1'b0;
  logic [AW-1:0] m_ptr  = '0;
  int            m_count = 0;
  logic          m_nop  = 1'b0;

  function automatic vec_t mk(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                              input logic [31:0] wd, input logic legal);
    vec_t v;
    v.kind = k; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.tgt = tgt; v.wd = wd; v.legal = legal;
    return v;
  endfunction

  function automatic logic is_br(input logic [3:0] k);
    return (k == 4'd11) || (k == 4'd12) || (k == 4'd13);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h wd 0x%0h, required no write", imem_addr, imem_wd);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.addr));
        chk("write_wd", 64'(imem_wd), 64'(e.wd));
      end
    end
  end

  task automatic send(input vec_t v, output logic acc);
    logic exp_ready;
    @(negedge clk);
    in_valid = 1'b1; in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_imm = v.imm; in_target = v.tgt;
    exp_ready = m_load && (m_count < DEPTH);
`ifdef INSTR_ENC_DELAY_SLOT_EN
    if (m_nop) exp_ready = 1'b0;
    if (is_br(v.kind) && (m_count >= DEPTH - 1)) exp_ready = 1'b0;
`endif
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    acc   = exp_ready;
    m_nop = 1'b0;
    if (acc && v.legal) begin
      sb.push_back('{m_ptr, v.wd});
      m_ptr++;
      m_count++;
`ifdef INSTR_ENC_DELAY_SLOT_EN
      if (is_br(v.kind)) begin
        sb.push_back('{m_ptr, 32'h0});
        m_ptr++;
        m_count++;
        m_nop = 1'b1;
      end
`endif
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      m_nop = 1'b0;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0;
    m_load = 1'b1; m_ptr = base; m_count = 0; m_nop = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_count", 64'(count), 64'(0));
    chk("start_errs", 64'({err_illegal, err_overflow}), 64'(0));
  endtask

  task automatic do_finish();
    @(negedge clk);
    in_valid = 1'b0; finish = 1'b1;
    @(negedge clk);
    finish = 1'b0; m_load = 1'b0;
    chk("done_pulse", 64'(done), 64'(1));
    chk("busy_after_finish", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done_single", 64'(done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    vec_t v;
    tbl[0]  = mk(4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0, 32'h00221820, 1'b1);
    tbl[1]  = mk(4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0, 32'h00853022, 1'b1);
    tbl[2]  = mk(4'd2,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h0, 32'h00E84824, 1'b1);
    tbl[3]  = mk(4'd3,  5'd10, 5'd11, 5'd12, 16'h0000, 26'h0, 32'h014B6025, 1'b1);
    tbl[4]  = mk(4'd4,  5'd13, 5'd14, 5'd15, 16'h0000, 26'h0, 32'h01AE782A, 1'b1);
    tbl[5]  = mk(4'd5,  5'd0,  5'd2,  5'd0,  16'h0050, 26'h0, 32'h8C020050, 1'b1);
    tbl[6]  = mk(4'd6,  5'd29, 5'd31, 5'd0,  16'h0004, 26'h0, 32'hAFBF0004, 1'b1);
    tbl[7]  = mk(4'd7,  5'd0,  5'd5,  5'd0,  16'h0007, 26'h0, 32'h20050007, 1'b1);
    tbl[8]  = mk(4'd8,  5'd1,  5'd1,  5'd0,  16'h00FF, 26'h0, 32'h302100FF, 1'b1);
    tbl[9]  = mk(4'd9,  5'd2,  5'd3,  5'd0,  16'hABCD, 26'h0, 32'h3443ABCD, 1'b1);
    tbl[10] = mk(4'd10, 5'd4,  5'd6,  5'd0,  16'h8000, 26'h0, 32'h28868000, 1'b1);
    tbl[11] = mk(4'd11, 5'd1,  5'd2,  5'd0,  16'hFFFE, 26'h0, 32'h1022FFFE, 1'b1);
    tbl[12] = mk(4'd12, 5'd3,  5'd4,  5'd0,  16'h0010, 26'h0, 32'h14640010, 1'b1);
    tbl[13] = mk(4'd13, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010, 1'b1);
    tbl[14] = mk(4'd13, 5'd7,  5'd7,  5'd7,  16'h1234, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b1);
    tbl[15] = mk(4'd14, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0, 32'h00000000, 1'b0);
    tbl[16] = mk(4'd15, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0, 32'h00000000, 1'b0);

    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; base_addr = '0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_addr_wd", 64'({imem_addr, imem_wd}), 64'(0));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_errs", 64'({err_illegal, err_overflow}), 64'(0));
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      do_start(AW'(8'h10 + i));
      send(tbl[i], acc);
      idle(3);
      chk("vec_count", 64'(count), 64'(m_count));
      chk("vec_err_illegal", 64'(err_illegal), 64'(!tbl[i].legal));
      do_finish();
    end

    // back-to-back LW, ADDI
    do_start(6'h10);
    send(tbl[5], acc);
    send(tbl[7], acc);
    idle(2);
    chk("b2b_count", 64'(count), 64'(2));
    do_finish();

    // BEQ then J, retried if the delay slot blocks it
    do_start(6'h10);
    send(tbl[11], acc);
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) send(tbl[13], acc);
    idle(3);
    chk("branch_count", 64'(count), 64'(m_count));
    do_finish();

    // illegal kind clears on restart
    do_start(6'h10);
    send(tbl[16], acc);
    idle(2);
    chk("illegal_flag", 64'(err_illegal), 64'(1));
    chk("illegal_count", 64'(count), 64'(0));
    do_start(6'h11);
    chk("illegal_cleared", 64'(err_illegal), 64'(0));
    do_finish();

    // full session with address wrap and overflow
    do_start(6'h3E);
    for (int i = 0; i < 5; i++) send(tbl[i], acc);
    idle(2);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_overflow", 64'(err_overflow), 64'(1));
    chk("full_ready", 64'(in_ready), 64'(0));
    do_start(6'h00);
    chk("overflow_cleared", 64'(err_overflow), 64'(0));
    do_finish();

    // finish together with a valid ADD
    do_start(6'h08);
    @(negedge clk);
    in_valid = 1'b1; finish = 1'b1; in_kind = tbl[0].kind; in_rs = tbl[0].rs;
    in_rt = tbl[0].rt; in_rd = tbl[0].rd; in_imm = tbl[0].imm; in_target = tbl[0].tgt;
    #1;
    chk("fin_in_ready", 64'(in_ready), 64'(1));
    sb.push_back('{6'h08, 32'h00221820});
    @(negedge clk);
    in_valid = 1'b0; finish = 1'b0; m_load = 1'b0;
    chk("fin_done", 64'(done), 64'(1));
    chk("fin_write", 64'(imem_we), 64'(1));
    chk("fin_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("fin_done_once", 64'(done), 64'(0));

    // reset mid-stream
    do_start(6'h20);
    send(tbl[1], acc);
    @(negedge clk);
    reset = 1'b0; m_load = 1'b0; m_count = 0;
    @(negedge clk);
    chk("mid_rst_we_ready", 64'({imem_we, in_ready}), 64'(0));
    chk("mid_rst_busy_done", 64'({busy, done}), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_addr_wd", 64'({imem_addr, imem_wd}), 64'(0));
    reset = 1'b1;
    send(tbl[2], acc);
    send(tbl[3], acc);
    idle(3);

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
